// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary encoder input conditioner.
package rotary_pkg;

  // Production defaults: 50000 stable samples at the system clock.
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int CNT_W_DEF           = 16;

  // Per-channel debounce state. IDLEx holds a settled level x,
  // PENDx is waiting for level x to stay stable long enough.
  localparam logic [1:0] ST_IDLE0 = 2'd0;
  localparam logic [1:0] ST_PEND1 = 2'd1;
  localparam logic [1:0] ST_IDLE1 = 2'd2;
  localparam logic [1:0] ST_PEND0 = 2'd3;

  typedef enum logic [1:0] {
    IDLE0 = ST_IDLE0,
    PEND1 = ST_PEND1,
    IDLE1 = ST_IDLE1,
    PEND0 = ST_PEND0
  } chan_state_e;

endpackage

// File: rtl/rotary_debounce_channel.sv
// One encoder pin: synchroniser, debounce FSM with stability counter,
// registered debounced level and one-cycle edge strobes.
module rotary_debounce_channel
  import rotary_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  // Terminal count: a change is accepted when the pending pin is still
  // stable with the counter at this value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  chan_state_e            state;
  logic [CNT_W-1:0]       cnt;

  // Synchroniser chain: shift the raw asynchronous pin into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
    end
  end

  // Only the last synchroniser stage is safe to use.
  assign s = sync_p0[SYNC_STAGES-1];

  // Debounce FSM: any opposite sample while pending drops back to the
  // settled state, so acceptance always needs a full uninterrupted run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE0: begin
          if (s) begin
            cnt   <= '0;
            state <= PEND1;
          end
        end
        PEND1: begin
          if (!s) begin
            state <= IDLE0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE1;
            level <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IDLE1: begin
          if (!s) begin
            cnt   <= '0;
            state <= PEND0;
          end
        end
        PEND0: begin
          if (s) begin
            state <= IDLE1;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE0;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rotary_input_conditioner.sv
// Rotary encoder front end: two independent debounced quadrature channels
// feeding the rotary level controller, plus edge strobes for status logic.
module rotary_input_conditioner
  import rotary_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rot_a_raw,
  input  logic rot_b_raw,
  output logic rotary_inc_a,
  output logic rotary_inc_b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  // Channel A: pin A conditioning.
  rotary_debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_a (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (rot_a_raw),
    .level(rotary_inc_a),
    .rise (a_rise),
    .fall (a_fall)
  );

  // Channel B: pin B conditioning, fully independent of A.
  rotary_debounce_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_b (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (rot_b_raw),
    .level(rotary_inc_b),
    .rise (b_rise),
    .fall (b_fall)
  );

endmodule
